// File: rtl/mem_req_pkg.sv
// Shared types and constants for the MEM-stage data-memory requester.
package mem_req_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_DEPTH_WORDS = 64;
  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned CNT_W           = 4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational request legality: exactly one op, word-aligned, inside the data window.
// Range compare is done in 33 bits so a window ending at 2^32 cannot wrap.
module mem_addr_check
  import mem_req_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                                 req_read_i,
  input  logic                                 req_write_i,
  input  logic [31:0]                          req_addr_i,
  output logic                                 addr_ok_o,
  output logic [idx_width(DEPTH_WORDS)-1:0]    word_index_o
);

  localparam int unsigned IW = idx_width(DEPTH_WORDS);
  localparam logic [32:0] LO = 33'(BASE_ADDR);
  localparam logic [32:0] HI = LO + 33'(WORD_BYTES * DEPTH_WORDS);

  logic [32:0] addr_ext;
  logic        in_range;
  logic        aligned;

  assign addr_ext     = {1'b0, req_addr_i};
  assign in_range     = (addr_ext >= LO) && (addr_ext < HI);
  assign aligned      = (req_addr_i[1:0] == 2'b00);
  assign addr_ok_o    = (req_read_i ^ req_write_i) && in_range && aligned;
  assign word_index_o = IW'((req_addr_i - 32'(BASE_ADDR)) >> 2);

endmodule

// File: rtl/mem_stage_requester.sv
// MEM-stage initiator: validates a load/store, drives memory for WAIT_STATES+1 cycles, freezes the pipe until DONE.
// Legal request completes WAIT_STATES+2 cycles after it appears, illegal in 1; MEM_STATS_EN adds 16-bit saturating counters.
module mem_stage_requester
  import mem_req_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        freeze,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        addr_err,
  output logic        MEMread,
  output logic        MEMwrite,
  output logic [31:0] address,
  output logic [31:0] data,
  input  logic [31:0] MEM_result
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes,
  output logic [15:0] stat_errs
`endif
);

  localparam int unsigned IW = idx_width(DEPTH_WORDS);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             rd_q;
  logic             err_q;

  logic             addr_ok;
  logic [IW-1:0]    word_index;
  logic             req_any;
  logic             in_access;

  mem_addr_check #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_check (
    .req_read_i   (req_read),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .addr_ok_o    (addr_ok),
    .word_index_o (word_index)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            if (addr_ok) begin
              idx_q   <= word_index;
              wdata_q <= req_wdata;
              rd_q    <= req_read;
              err_q   <= 1'b0;
              cnt_q   <= CNT_W'(WAIT_STATES);
              state_q <= ACCESS;
            end else begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (rd_q) rdata_q <= MEM_result;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_any   = req_read | req_write;
  assign in_access = (state_q == ACCESS);

  // Freeze drops in DONE so the pipeline advances exactly once per request.
  assign freeze    = ((state_q == IDLE) && req_any) || in_access;
  assign rsp_valid = (state_q == DONE);
  assign addr_err  = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

  // Stores strobe only in the last ACCESS cycle so memory sees a single write edge.
  assign MEMread   = in_access && rd_q;
  assign MEMwrite  = in_access && !rd_q && (cnt_q == '0);
  assign address   = in_access ? (32'(BASE_ADDR) + 32'({idx_q, 2'b00})) : '0;
  assign data      = in_access ? wdata_q : '0;

`ifdef MEM_STATS_EN
  logic [15:0] reads_q;
  logic [15:0] writes_q;
  logic [15:0] errs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reads_q  <= '0;
      writes_q <= '0;
      errs_q   <= '0;
    end else if (state_q == DONE) begin
      if (err_q) begin
        if (errs_q != 16'hFFFF) errs_q <= errs_q + 1'b1;
      end else if (rd_q) begin
        if (reads_q != 16'hFFFF) reads_q <= reads_q + 1'b1;
      end else begin
        if (writes_q != 16'hFFFF) writes_q <= writes_q + 1'b1;
      end
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_errs   = errs_q;
`endif

endmodule
